// File: rtl/ser_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ser_tx_arbiter
//
// Shares one UART serial TX line between NUM_REQ byte producers. Requesters
// are granted round-robin and each granted byte is sent as an 8N1 frame
// (start 0, eight data bits LSB first, stop 1) at CLKDIV clocks per bit.
//
// Handshake: a requester raises req_valid[i] with its byte on
// req_data[8*i+7:8*i] and holds both stable until it sees req_ready[i].
// A transfer happens on the rising clk edge where req_valid[i] & req_ready[i]
// are both high. req_ready is a combinational one-hot grant that is only
// ever high while the transmitter is idle, enable is high and reset is low.
// Dropping req_valid before that edge is legal and simply withdraws the
// request; valids raised while a frame is in flight are not looked at.
//
// Ports
//   clk           system clock, all state on posedge
//   reset         asynchronous, active-high reset
//   enable        1 = new grants allowed; an in-flight frame always completes
//   req_valid     per-requester byte available
//   req_data      byte for requester i at [8*i+7:8*i]
//   req_ready     one-hot grant (combinational, idle only)
//   ser_tx        registered serial line, idles high
//   busy          frame in progress (START..STOP)
//   grant_id      index of the last granted requester
//   byte_cnt      frames completed, wraps 255 -> 0
//   dbg_state     current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//   dbg_prio_ptr  requester index that has highest priority next
// ---------------------------------------------------------------------------
module ser_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CLKDIV  = 3,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int DIVW   = (CLKDIV > 1) ? $clog2(CLKDIV) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 ser_tx,
    output logic                 busy,
    output logic [IDW-1:0]       grant_id,
    output logic [7:0]           byte_cnt,
    output logic [1:0]           dbg_state,
    output logic [IDW-1:0]       dbg_prio_ptr
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;

    logic [DIVW-1:0] div_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            ser_tx_q;
    logic            busy_q;
    logic [IDW-1:0]  grant_id_q;
    logic [IDW-1:0]  prio_ptr_q;
    logic [7:0]      byte_cnt_q;

    logic            div_last;
    logic            win_found;
    logic [IDW-1:0]  win_idx;
    logic [IDW:0]    cand;
    logic            arb_go;
    logic [IDW-1:0]  ptr_after;

    // Last clock of the current bit period.
    assign div_last = (div_q == DIVW'(CLKDIV - 1));

    // -----------------------------------------------------------------------
    // Round-robin search: first valid requester at or above prio_ptr,
    // wrapping modulo NUM_REQ. cand is one bit wider so the wrap subtraction
    // never overflows.
    // -----------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, prio_ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NUM_REQ)) begin
                cand = cand - (IDW+1)'(NUM_REQ);
            end
            if (!win_found && req_valid[cand[IDW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDW-1:0];
            end
        end
    end

    // A grant is offered (and, because ready is only raised for a valid
    // requester, also taken) whenever we are idle, enabled and someone asks.
    assign arb_go    = (state_q == S_IDLE) && enable && win_found;
    assign ptr_after = (win_idx == IDW'(NUM_REQ - 1)) ? '0 : win_idx + IDW'(1);

    // -----------------------------------------------------------------------
    // FSM state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (arb_go)                      state_d = S_START;
            S_START: if (div_last)                    state_d = S_DATA;
            S_DATA:  if (div_last && bit_q == 3'd7)   state_d = S_STOP;
            S_STOP:  if (div_last)                    state_d = S_IDLE;
            default:                                  state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM outputs: combinational one-hot grant. Gated by reset so that no
    // grant is ever shown while the block is held in reset.
    // -----------------------------------------------------------------------
    always_comb begin
        req_ready = '0;
        if (arb_go && !reset) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // Datapath: bit divider, bit counter, shift register and the registered
    // line. ser_tx is always loaded one edge ahead of the bit it carries, so
    // the start bit appears the cycle right after the handshake edge.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            ser_tx_q   <= 1'b1;
            busy_q     <= 1'b0;
            grant_id_q <= '0;
            prio_ptr_q <= '0;
            byte_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (arb_go) begin
                        shift_q    <= req_data[8*win_idx +: 8];
                        grant_id_q <= win_idx;
                        prio_ptr_q <= ptr_after;
                        ser_tx_q   <= 1'b0;
                        busy_q     <= 1'b1;
                        div_q      <= '0;
                        bit_q      <= '0;
                    end
                end
                S_START: begin
                    if (div_last) begin
                        div_q    <= '0;
                        ser_tx_q <= shift_q[0];
                    end else begin
                        div_q <= div_q + DIVW'(1);
                    end
                end
                S_DATA: begin
                    if (div_last) begin
                        div_q <= '0;
                        if (bit_q == 3'd7) begin
                            ser_tx_q <= 1'b1;
                        end else begin
                            bit_q    <= bit_q + 3'd1;
                            shift_q  <= shift_q >> 1;
                            ser_tx_q <= shift_q[1];
                        end
                    end else begin
                        div_q <= div_q + DIVW'(1);
                    end
                end
                S_STOP: begin
                    if (div_last) begin
                        div_q      <= '0;
                        busy_q     <= 1'b0;
                        byte_cnt_q <= byte_cnt_q + 8'd1;
                    end else begin
                        div_q <= div_q + DIVW'(1);
                    end
                end
                default: begin
                    div_q <= '0;
                end
            endcase
        end
    end

    assign ser_tx       = ser_tx_q;
    assign busy         = busy_q;
    assign grant_id     = grant_id_q;
    assign byte_cnt     = byte_cnt_q;
    assign dbg_state    = state_q;
    assign dbg_prio_ptr = prio_ptr_q;

endmodule

// File: tb/tb_ser_tx_arbiter.sv
`timescale 1ns/1ps
module tb_ser_tx_arbiter;

    localparam int NUM_REQ     = 4;
    localparam int CLKDIV      = 3;
    localparam int FRAME       = 10 * CLKDIV;
    localparam int RAND_FRAMES = 245;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        ser_tx;
    logic        busy;
    logic [1:0]  grant_id;
    logic [7:0]  byte_cnt;
    logic [1:0]  dbg_state;
    logic [1:0]  dbg_prio_ptr;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ser_tx_arbiter #(.NUM_REQ(NUM_REQ), .CLKDIV(CLKDIV)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .ser_tx       (ser_tx),
        .busy         (busy),
        .grant_id     (grant_id),
        .byte_cnt     (byte_cnt),
        .dbg_state    (dbg_state),
        .dbg_prio_ptr (dbg_prio_ptr)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 60)
                $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Frame-level view: a frame lasts FRAME cycles after the grant edge; the
    // line level in cycle p of the frame is slot p/CLKDIV of
    // {start, d0..d7, stop}.
    int         m_rem = 0;
    int         m_ptr = 0;
    int         m_gid = 0;
    int         m_cnt = 0;
    logic [7:0] m_byte = 8'h00;
    logic [7:0] exp_q[$];

    always @(negedge clk) begin
        logic [3:0] e_ready;
        logic       e_ser;
        int         g;
        int         c;
        int         slot;
        if (reset) begin
            check("rst_ser_tx", ser_tx, 1);
            check("rst_busy", busy, 0);
            check("rst_ready", req_ready, 0);
            check("rst_byte_cnt", byte_cnt, 0);
            check("rst_grant_id", grant_id, 0);
            check("rst_prio_ptr", dbg_prio_ptr, 0);
            if (m_rem != 0) void'(exp_q.pop_back());
            m_rem = 0; m_ptr = 0; m_gid = 0; m_cnt = 0;
        end else begin
            e_ready = 4'b0000;
            g = -1;
            if (m_rem == 0 && enable) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    c = (m_ptr + k) % NUM_REQ;
                    if (g < 0 && req_valid[c]) g = c;
                end
            end
            if (g >= 0) e_ready[g] = 1'b1;
            if (m_rem == 0) begin
                e_ser = 1'b1;
            end else begin
                slot = (FRAME - m_rem) / CLKDIV;
                e_ser = (slot == 0) ? 1'b0 : (slot == 9) ? 1'b1 : m_byte[slot-1];
            end
            check("m_ready", req_ready, e_ready);
            check("m_busy", busy, (m_rem != 0));
            check("m_ser_tx", ser_tx, e_ser);
            check("m_grant_id", grant_id, m_gid);
            check("m_byte_cnt", byte_cnt, m_cnt);
            check("m_prio_ptr", dbg_prio_ptr, m_ptr);
            if (g >= 0) begin
                m_byte = req_data[8*g +: 8];
                exp_q.push_back(m_byte);
                m_gid = g;
                m_ptr = (g + 1) % NUM_REQ;
                m_rem = FRAME;
            end else if (m_rem > 0) begin
                m_rem--;
                if (m_rem == 0) m_cnt = (m_cnt + 1) % 256;
            end
        end
    end

    // ---------------- serial monitor / scoreboard ----------------
    int         mon_pos = -1;
    logic [7:0] mon_byte = 8'h00;
    logic [7:0] dec_log[$];

    always @(negedge clk) begin
        if (reset) begin
            mon_pos = -1;
        end else if (mon_pos < 0) begin
            if (ser_tx == 1'b0) mon_pos = 0;
        end else begin
            mon_pos++;
            for (int k = 0; k < 8; k++)
                if (mon_pos == CLKDIV*(k+1) + CLKDIV/2) mon_byte[k] = ser_tx;
            if (mon_pos == 9*CLKDIV + CLKDIV/2) begin
                check("mon_stop_bit", ser_tx, 1);
                if (exp_q.size() == 0) begin
                    check("mon_unexpected_frame", 1, 0);
                end else begin
                    check("mon_byte", mon_byte, exp_q.pop_front());
                end
                dec_log.push_back(mon_byte);
                mon_pos = -1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Waits for req_ready[id], then consumes the handshake edge.
    task automatic wait_ready(input int id, input string name);
        bit ok = 0;
        for (int c = 0; c < 2000 && !ok; c++) begin
            @(negedge clk);
            if (req_ready[id]) ok = 1;
        end
        check({name, "_ready_timeout"}, ok, 1);
        tick();
    endtask

    task automatic wait_frame_done(input string name);
        bit ok = 0;
        for (int c = 0; c < 4*FRAME && !ok; c++) begin
            @(negedge clk);
            if (!busy) ok = 1;
        end
        check({name, "_done_timeout"}, ok, 1);
        tick();
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       en;
        logic [3:0] valid;
        logic [3:0] exp_ready;
        logic [1:0] exp_gid;
        logic [1:0] exp_ptr;
    } vec_t;

    vec_t tbl[11];

    typedef struct {
        int         id;
        logic [7:0] d;
    } item_t;

    item_t pend_q[$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] got_bits;
        logic [3:0]  rv_q[$];
        int          gcyc[$];
        int          order[5];
        int          sent;
        logic [3:0]  hs;
        logic [3:0]  cur_has;
        bit          found;
        string       hello;

        // row order starts from prio_ptr = 0 after reset
        tbl[0]  = '{1'b1, 4'b0001, 4'b0001, 2'd0, 2'd1};
        tbl[1]  = '{1'b0, 4'b1111, 4'b0000, 2'd0, 2'd1};
        tbl[2]  = '{1'b1, 4'b1111, 4'b0010, 2'd1, 2'd2};
        tbl[3]  = '{1'b1, 4'b1000, 4'b1000, 2'd3, 2'd0};
        tbl[4]  = '{1'b1, 4'b0100, 4'b0100, 2'd2, 2'd3};
        tbl[5]  = '{1'b1, 4'b1010, 4'b1000, 2'd3, 2'd0};
        tbl[6]  = '{1'b1, 4'b1010, 4'b0010, 2'd1, 2'd2};
        tbl[7]  = '{1'b1, 4'b0000, 4'b0000, 2'd1, 2'd2};
        tbl[8]  = '{1'b1, 4'b0011, 4'b0001, 2'd0, 2'd1};
        tbl[9]  = '{1'b1, 4'b0110, 4'b0010, 2'd1, 2'd2};
        tbl[10] = '{1'b1, 4'b0001, 4'b0001, 2'd0, 2'd1};

        reset = 1'b1; enable = 1'b0; req_valid = 4'b0000; req_data = 32'h0;
        repeat (3) tick();
        check("reset_ser_tx", ser_tx, 1);
        check("reset_busy", busy, 0);
        check("reset_ready", req_ready, 0);
        reset = 1'b0;
        tick();

        // --- reset during DATA bit 4 (line must jump high at once) ---
        enable = 1'b1;
        req_data[7:0] = 8'hA5;
        req_valid = 4'b0001;
        wait_ready(0, "t4");
        req_valid = 4'b0000;
        repeat (16) @(posedge clk);
        #1;
        check("t4_busy_mid_frame", busy, 1);
        check("t4_bit4_level", ser_tx, 0);
        reset = 1'b1;
        #1;
        check("t4_ser_tx_abort", ser_tx, 1);
        check("t4_busy_abort", busy, 0);
        check("t4_byte_cnt_abort", byte_cnt, 0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        // --- single byte 0x48: exact waveform ---
        req_data[7:0] = 8'h48;
        req_valid = 4'b0001;
        wait_ready(0, "t1");
        req_valid = 4'b0000;
        for (int j = 0; j < FRAME; j++) begin
            @(negedge clk);
            got_bits[j] = ser_tx;
        end
        check("t1_frame_bits", got_bits, 30'b111_000_111_000_000_111_000_000_000_000);
        @(negedge clk);
        check("t1_busy_low_T31", busy, 0);
        check("t1_byte_cnt", byte_cnt, 1);
        tick();

        // --- table-driven arbitration ---
        do_reset();
        for (int k = 0; k < 11; k++) begin
            enable = tbl[k].en;
            req_valid = tbl[k].valid;
            req_data = 32'h40302010 + {4{8'(k)}};
            @(negedge clk);
            check($sformatf("tbl%0d_ready", k), req_ready, tbl[k].exp_ready);
            tick();
            req_valid = 4'b0000;
            if (tbl[k].exp_ready != 4'b0000) wait_frame_done($sformatf("tbl%0d", k));
            check($sformatf("tbl%0d_grant_id", k), grant_id, tbl[k].exp_gid);
            check($sformatf("tbl%0d_prio_ptr", k), dbg_prio_ptr, tbl[k].exp_ptr);
        end

        // --- all four valid continuously: order 0,1,2,3,0 and 31-cycle spacing ---
        do_reset();
        enable = 1'b1;
        req_data = 32'h44332211;
        req_valid = 4'b1111;
        order = '{0, 1, 2, 3, 0};
        for (int c = 0; c < 400 && gcyc.size() < 5; c++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                gcyc.push_back(cyc);
                rv_q.push_back(req_ready);
            end
        end
        tick();
        req_valid = 4'b0000;
        check("t2_grant_count", gcyc.size(), 5);
        for (int i = 0; i < rv_q.size(); i++)
            check($sformatf("t2_grant%0d", i), rv_q[i], 4'b0001 << order[i]);
        for (int i = 1; i < gcyc.size(); i++)
            check($sformatf("t2_spacing%0d", i), gcyc[i] - gcyc[i-1], 31);
        wait_frame_done("t2");

        // --- enable low blocks grants; dropping it mid-frame only stops new ones ---
        enable = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("t5_ready_blocked", req_ready, 0);
            check("t5_line_idle", ser_tx, 1);
        end
        tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        check("t5_frame_started", busy, 1);
        wait_frame_done("t5");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("t5_no_further_grant", {req_ready, busy}, 0);
        end
        tick();
        req_valid = 4'b0000;

        // --- "Hello World" through mixed requesters, then wrap at 256 frames ---
        do_reset();
        dec_log.delete();
        enable = 1'b1;
        hello = "Hello World";
        for (int i = 0; i < hello.len(); i++) begin
            int id;
            id = $urandom_range(0, 3);
            req_data[8*id +: 8] = hello[i];
            req_valid = 4'b0001 << id;
            wait_ready(id, "t6_hello");
            req_valid = 4'b0000;
        end
        wait_frame_done("t6_hello");
        check("t6_decoded_count", dec_log.size(), 11);
        for (int i = 0; i < 11 && i < dec_log.size(); i++)
            check($sformatf("t6_char%0d", i), dec_log[i], hello[i]);

        for (int i = 0; i < RAND_FRAMES; i++)
            pend_q.push_back('{$urandom_range(0, 3), 8'($urandom_range(0, 255))});
        cur_has = 4'b0000;
        sent = 0;
        for (int c = 0; c < 40000 && sent < RAND_FRAMES; c++) begin
            @(negedge clk);
            hs = req_ready & req_valid;
            tick();
            for (int i = 0; i < NUM_REQ; i++) begin
                if (hs[i]) begin
                    cur_has[i] = 1'b0;
                    req_valid[i] = 1'b0;
                    sent++;
                end
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                found = 0;
                if (!cur_has[i]) begin
                    for (int j = 0; j < pend_q.size(); j++) begin
                        if (!found && pend_q[j].id == i) begin
                            req_data[8*i +: 8] = pend_q[j].d;
                            cur_has[i] = 1'b1;
                            pend_q.delete(j);
                            found = 1;
                        end
                    end
                end
            end
            // occasional withdrawals and enable gaps
            for (int i = 0; i < NUM_REQ; i++)
                req_valid[i] = cur_has[i] && ($urandom_range(0, 7) != 0);
            enable = ($urandom_range(0, 7) != 0);
        end
        req_valid = 4'b0000;
        enable = 1'b1;
        check("t6_random_sent", sent, RAND_FRAMES);
        wait_frame_done("t6_random");
        repeat (2) tick();
        check("t6_byte_cnt_wrap", byte_cnt, (11 + RAND_FRAMES) % 256);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
